request_unit: RTL and testbench
===============================

Name: request_unit

Overview:
- Sits between the control unit and the memory/cache side of the datapath.
- Turns the control unit's per-instruction iREN/dREN/dWEN/halt requests into held imemREN/dmemREN/dmemWEN memory requests.
- Sequences one instruction fetch, then at most one data access, per instruction.
- Generates pc_en so the PC advances only when the instruction's memory work is done; also keeps saturating stall counters for debug.

Parameters:
- CNT_W, 32, width of each stall counter (saturating).

Ports:
- CLK  input  1  system clock, rising edge.
- nRST  input  1  synchronous active-low reset.
- ctrl_iREN  input  1  control unit requests instruction fetch (normally 1).
- ctrl_dREN  input  1  decoded instruction is a load.
- ctrl_dWEN  input  1  decoded instruction is a store.
- ctrl_halt  input  1  decoded instruction is HALT.
- ihit  input  1  instruction memory/cache returns valid instruction this cycle.
- dhit  input  1  data memory/cache completes the access this cycle.
- imemREN  output  1  instruction read request.
- dmemREN  output  1  data read request (registered, held until dhit).
- dmemWEN  output  1  data write request (registered, held until dhit).
- pc_en  output  1  one-cycle PC advance strobe.
- halt  output  1  sticky halted flag.
- req_err  output  1  sticky: ctrl_dREN and ctrl_dWEN were both high at an accepted fetch.
- istall_cnt  output  CNT_W  cycles in IFETCH with imemREN=1 and ihit=0.
- dstall_cnt  output  CNT_W  cycles in DATA with dhit=0.

Behaviour:
- All state changes on rising CLK.
- When nRST=0 at an edge:
  - state<=IDLE; dmemREN, dmemWEN, halt, req_err <= 0; counters <= 0.
  - Reset applies from any state, including mid-DATA: a pending access is dropped with no completion pulse.
- FSM states: IDLE, IFETCH, DATA, HALTED.
- IDLE:
  - All request outputs 0, pc_en=0.
  - Next state is IFETCH unconditionally, giving one quiet cycle after reset.
- IFETCH:
  - imemREN = ctrl_iREN (combinational).
  - On ihit=1 with ctrl_iREN=1, memop = ctrl_dREN|ctrl_dWEN:
    - ctrl_halt=1 (priority over memop): next HALTED, halt<=1, pc_en=0.
    - Otherwise if memop=1: next DATA, pc_en=0.
      - If ctrl_dWEN=1: dmemWEN<=1, dmemREN<=0.
      - Otherwise: dmemREN<=1.
      - If both ctrl_dREN and ctrl_dWEN are set, the write wins and req_err<=1.
    - Otherwise: pc_en=1 this cycle; stay IFETCH.
  - ihit=0: stay, istall_cnt+1 if imemREN=1.
  - dhit while in IFETCH is ignored.
- DATA:
  - imemREN=0; dmemREN/dmemWEN hold their registered values; control inputs are ignored.
  - dhit=1: pc_en=1 this cycle; dmemREN<=0, dmemWEN<=0; next IFETCH.
  - dhit=0: stay, dstall_cnt+1.
  - ihit while in DATA is ignored.
- HALTED:
  - All requests 0, pc_en=0, halt=1.
  - Exits only via reset.
- pc_en is combinational from state and hits; it is never high in IDLE or HALTED.
- At most one of imemREN/dmemREN/dmemWEN is high in any cycle.
- Counters saturate at 2^CNT_W-1 and never wrap.
- Latency:
  - Non-memory instruction: pc_en in the same cycle as ihit.
  - Load/store: dmem request is visible the cycle after ihit; pc_en in the dhit cycle.
  - Minimum two cycles per load/store.

Test Plan:
- Reset, then ihit=1 every cycle, no memop → imemREN=0 in first cycle (IDLE), then imemREN=1 and pc_en=1 every cycle; counters stay 0.
- Fetch with ihit low 3 cycles then high, ctrl_dREN=1 → istall_cnt=3. Next cycle: dmemREN=1, imemREN=0. dhit after 2 wait cycles → pc_en pulses once, dstall_cnt=2, back to IFETCH with imemREN=1.
- ctrl_dWEN=1 with dhit same cycle as the dmem request's first cycle → dmemWEN high exactly 1 cycle, pc_en=1 in that cycle, pc_en=0 in the ihit cycle.
- ctrl_dREN=ctrl_dWEN=1 at ihit → dmemWEN=1, dmemREN=0, req_err=1 and remains 1 after completion until reset.
- ctrl_halt=1 with ctrl_dREN=1 at ihit → halt=1, no dmem request, pc_en stays 0 for 10 further cycles of ihit/dhit toggling.
- nRST=0 mid-DATA (dmemREN=1) → next cycle dmemREN=0, pc_en=0, counters=0, state IDLE. With CNT_W=4 and ihit held 0 for 20 cycles → istall_cnt saturates at 15.

Source files
------------

// File: rtl/request_unit.sv
// Sequences one instruction fetch then at most one data access per instruction, and strobes pc_en when done.
// Latency: pc_en in the ihit cycle for non-memory ops; dmem request the cycle after ihit, pc_en in the dhit cycle.
// Backpressure: requests are held while ihit/dhit stay low, with saturating stall counters tracking the wait.
module request_unit #(
    parameter int CNT_W = 32
) (
    input  logic             CLK,
    input  logic             nRST,
    input  logic             ctrl_iREN,
    input  logic             ctrl_dREN,
    input  logic             ctrl_dWEN,
    input  logic             ctrl_halt,
    input  logic             ihit,
    input  logic             dhit,
    output logic             imemREN,
    output logic             dmemREN,
    output logic             dmemWEN,
    output logic             pc_en,
    output logic             halt,
    output logic             req_err,
    output logic [CNT_W-1:0] istall_cnt,
    output logic [CNT_W-1:0] dstall_cnt
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        IFETCH = 2'd1,
        DATA   = 2'd2,
        HALTED = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    state_t           state;
    logic             dren_q;
    logic             dwen_q;
    logic             halt_q;
    logic             err_q;
    logic [CNT_W-1:0] ist_q;
    logic [CNT_W-1:0] dst_q;

    logic fetch_acc;
    logic memop;

    assign memop     = ctrl_dREN | ctrl_dWEN;
    assign fetch_acc = (state == IFETCH) && ctrl_iREN && ihit;

    assign imemREN    = (state == IFETCH) && ctrl_iREN;
    assign dmemREN    = dren_q;
    assign dmemWEN    = dwen_q;
    assign halt       = halt_q;
    assign req_err    = err_q;
    assign istall_cnt = ist_q;
    assign dstall_cnt = dst_q;

    // Only the instruction's final memory event advances the PC.
    assign pc_en = (fetch_acc && !ctrl_halt && !memop) || ((state == DATA) && dhit);

    always_ff @(posedge CLK) begin
        if (!nRST) begin
            state  <= IDLE;
            dren_q <= 1'b0;
            dwen_q <= 1'b0;
            halt_q <= 1'b0;
            err_q  <= 1'b0;
            ist_q  <= '0;
            dst_q  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    state <= IFETCH;
                end
                IFETCH: begin
                    if (fetch_acc) begin
                        if (ctrl_halt) begin
                            state  <= HALTED;
                            halt_q <= 1'b1;
                        end else if (memop) begin
                            state <= DATA;
                            // A store wins when both are requested; flag the bad decode.
                            if (ctrl_dWEN) begin
                                dwen_q <= 1'b1;
                                dren_q <= 1'b0;
                                if (ctrl_dREN) begin
                                    err_q <= 1'b1;
                                end
                            end else begin
                                dren_q <= 1'b1;
                            end
                        end
                    end else if (ctrl_iREN && !ihit && (ist_q != CNT_MAX)) begin
                        ist_q <= ist_q + CNT_ONE;
                    end
                end
                DATA: begin
                    if (dhit) begin
                        state  <= IFETCH;
                        dren_q <= 1'b0;
                        dwen_q <= 1'b0;
                    end else if (dst_q != CNT_MAX) begin
                        dst_q <= dst_q + CNT_ONE;
                    end
                end
                HALTED: begin
                    state <= HALTED;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_request_unit.sv
// Bench for request_unit: directed vector table, hand sequences for halt/reset/saturation, then random vs a reference model.
module tb_request_unit;

    localparam int CNT_W = 4;

    logic             CLK;
    logic             nRST;
    logic             ctrl_iREN;
    logic             ctrl_dREN;
    logic             ctrl_dWEN;
    logic             ctrl_halt;
    logic             ihit;
    logic             dhit;
    logic             imemREN;
    logic             dmemREN;
    logic             dmemWEN;
    logic             pc_en;
    logic             halt;
    logic             req_err;
    logic [CNT_W-1:0] istall_cnt;
    logic [CNT_W-1:0] dstall_cnt;

    request_unit #(.CNT_W(CNT_W)) dut (
        .CLK        (CLK),
        .nRST       (nRST),
        .ctrl_iREN  (ctrl_iREN),
        .ctrl_dREN  (ctrl_dREN),
        .ctrl_dWEN  (ctrl_dWEN),
        .ctrl_halt  (ctrl_halt),
        .ihit       (ihit),
        .dhit       (dhit),
        .imemREN    (imemREN),
        .dmemREN    (dmemREN),
        .dmemWEN    (dmemWEN),
        .pc_en      (pc_en),
        .halt       (halt),
        .req_err    (req_err),
        .istall_cnt (istall_cnt),
        .dstall_cnt (dstall_cnt)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Observed outputs: {imemREN, dmemREN, dmemWEN, pc_en, halt, req_err, istall, dstall}
    logic [13:0] outv;
    assign outv = {imemREN, dmemREN, dmemWEN, pc_en, halt, req_err, istall_cnt, dstall_cnt};

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic [6:0]  in;   // {nRST, iREN, dREN, dWEN, halt, ihit, dhit}
        logic [13:0] exp;
    } vec_t;

    vec_t tbl[19];

    task automatic check(input string nm, input logic [13:0] act, input logic [13:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got=%b required=%b", nm, act, exp);
        end
    endtask

    // Drive inputs, compare outputs at the falling edge, then advance one clock.
    task automatic step(input logic [6:0] in, input logic [13:0] exp, input string nm, input bit chk);
        {nRST, ctrl_iREN, ctrl_dREN, ctrl_dWEN, ctrl_halt, ihit, dhit} = in;
        @(negedge CLK);
        if (chk) check(nm, outv, exp);
        @(posedge CLK);
        #1;
    endtask

    // Reference model: transaction view (started / halted / which data op is outstanding).
    bit          m_started;
    bit          m_halted;
    int          m_pend;      // 0 none, 1 read outstanding, 2 write outstanding
    bit          m_err;
    int          m_ist;
    int          m_dst;

    function automatic logic [13:0] model_out(input logic [6:0] in);
        logic iren, dren, dwen, hlt, ih, dh;
        logic o_i, o_r, o_w, o_pc;
        {iren, dren, dwen, hlt, ih, dh} = in[5:0];
        o_i = 1'b0; o_r = 1'b0; o_w = 1'b0; o_pc = 1'b0;
        if (m_started && !m_halted) begin
            if (m_pend == 0) begin
                o_i  = iren;
                o_pc = iren && ih && !hlt && !(dren || dwen);
            end else begin
                o_r  = (m_pend == 1);
                o_w  = (m_pend == 2);
                o_pc = dh;
            end
        end
        return {o_i, o_r, o_w, o_pc, m_halted, m_err, 4'(m_ist), 4'(m_dst)};
    endfunction

    task automatic model_edge(input logic [6:0] in);
        logic nr, iren, dren, dwen, hlt, ih, dh;
        {nr, iren, dren, dwen, hlt, ih, dh} = in;
        if (!nr) begin
            m_started = 0; m_halted = 0; m_pend = 0; m_err = 0; m_ist = 0; m_dst = 0;
        end else if (!m_started) begin
            m_started = 1;
        end else if (m_halted) begin
            m_halted = 1;
        end else if (m_pend == 0) begin
            if (iren && ih) begin
                if (hlt) m_halted = 1;
                else if (dwen) begin
                    m_pend = 2;
                    if (dren) m_err = 1;
                end else if (dren) m_pend = 1;
            end else if (iren) begin
                m_ist = (m_ist < 15) ? m_ist + 1 : 15;
            end
        end else begin
            if (dh) m_pend = 0;
            else m_dst = (m_dst < 15) ? m_dst + 1 : 15;
        end
    endtask

    initial begin
        logic [6:0] rin;
        logic [13:0] rexp;

        tbl[0]  = '{7'b1100010, {6'b000000, 4'd0, 4'd0}};
        tbl[1]  = '{7'b1100010, {6'b100100, 4'd0, 4'd0}};
        tbl[2]  = '{7'b1100010, {6'b100100, 4'd0, 4'd0}};
        tbl[3]  = '{7'b1100010, {6'b100100, 4'd0, 4'd0}};
        tbl[4]  = '{7'b1110000, {6'b100000, 4'd0, 4'd0}};
        tbl[5]  = '{7'b1110000, {6'b100000, 4'd1, 4'd0}};
        tbl[6]  = '{7'b1110000, {6'b100000, 4'd2, 4'd0}};
        tbl[7]  = '{7'b1110010, {6'b100000, 4'd3, 4'd0}};
        tbl[8]  = '{7'b1100000, {6'b010000, 4'd3, 4'd0}};
        tbl[9]  = '{7'b1100000, {6'b010000, 4'd3, 4'd1}};
        tbl[10] = '{7'b1100001, {6'b010100, 4'd3, 4'd2}};
        tbl[11] = '{7'b1100000, {6'b100000, 4'd3, 4'd2}};
        tbl[12] = '{7'b1101010, {6'b100000, 4'd4, 4'd2}};
        tbl[13] = '{7'b1100001, {6'b001100, 4'd4, 4'd2}};
        tbl[14] = '{7'b1100000, {6'b100000, 4'd4, 4'd2}};
        tbl[15] = '{7'b1111010, {6'b100000, 4'd5, 4'd2}};
        tbl[16] = '{7'b1100000, {6'b001001, 4'd5, 4'd2}};
        tbl[17] = '{7'b1100001, {6'b001101, 4'd5, 4'd3}};
        tbl[18] = '{7'b1100010, {6'b100101, 4'd5, 4'd3}};

        {nRST, ctrl_iREN, ctrl_dREN, ctrl_dWEN, ctrl_halt, ihit, dhit} = 7'b0100010;
        @(posedge CLK);
        @(posedge CLK);
        #1;

        for (int i = 0; i < 19; i++) begin
            step(tbl[i].in, tbl[i].exp, $sformatf("vec%0d", i), 1'b1);
        end

        // Halt takes priority over a load; nothing moves afterwards.
        step(7'b1110110, {6'b100001, 4'd5, 4'd3}, "halt_accept", 1'b1);
        for (int i = 0; i < 10; i++) begin
            step({5'b11000, 1'(i % 2), 1'(~(i % 2))}, {6'b000011, 4'd5, 4'd3},
                 $sformatf("halted%0d", i), 1'b1);
        end

        // Reset mid-DATA drops the access; then saturate the fetch stall counter.
        step(7'b0100000, 14'd0, "rst", 1'b0);
        step(7'b1100000, {6'b000000, 4'd0, 4'd0}, "idle_after_rst", 1'b1);
        step(7'b1110010, {6'b100000, 4'd0, 4'd0}, "load_fetch", 1'b1);
        step(7'b1100000, {6'b010000, 4'd0, 4'd0}, "load_wait0", 1'b1);
        step(7'b1100000, {6'b010000, 4'd0, 4'd1}, "load_wait1", 1'b1);
        step(7'b0100000, {6'b010000, 4'd0, 4'd2}, "rst_mid_data", 1'b1);
        step(7'b1100001, {6'b000000, 4'd0, 4'd0}, "dropped_access", 1'b1);
        for (int k = 0; k < 20; k++) begin
            step(7'b1100000, {6'b100000, 4'((k < 15) ? k : 15), 4'd0},
                 $sformatf("ist_sat%0d", k), 1'b1);
        end

        // Randomized run against the reference model.
        rin = 7'b0100000;
        step(rin, 14'd0, "rand_rst", 1'b0);
        model_edge(rin);
        for (int n = 0; n < 600; n++) begin
            rin[6] = ($urandom_range(0, 99) != 0);
            rin[5] = ($urandom_range(0, 9) != 0);
            rin[4] = 1'($urandom_range(0, 1));
            rin[3] = 1'($urandom_range(0, 1));
            rin[2] = ($urandom_range(0, 39) == 0);
            rin[1] = 1'($urandom_range(0, 1));
            rin[0] = 1'($urandom_range(0, 1));
            if (rin[2]) rin[3] = 1'b0;
            rexp = model_out(rin);
            step(rin, rexp, $sformatf("rand%0d", n), 1'b1);
            model_edge(rin);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
